cr_dequeue: RTL and testbench
=============================

CR_DEQUEUE -- requirements
Module: cr_dequeue

Interface
REQ-001 SHALL take parameter FLOW_ID_W, default `FLOW_ID_W, flow identifier width.
REQ-002 SHALL take entry and queue widths from `FLOW_SEQ_NUM_W, `TX_CNT_W, `MAX_PKT_QUEUE_SIZE, `PKT_QUEUE_IND_W, `MAX_QUEUE_BITS and `MAX_TX_ID_BITS, with empty-slot marker `FLOW_SEQ_NONE.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-004 SHALL have context-load ports: ctx_valid in 1; ctx_ready out 1; flow_id_in in FLOW_ID_W; deq_cnt_in in PKT_QUEUE_IND_W (entries requested).
REQ-005 SHALL have queue-context input ports: pkt_queue_in in MAX_QUEUE_BITS; tx_id_queue_in in MAX_TX_ID_BITS; pkt_queue_head_in in PKT_QUEUE_IND_W; pkt_queue_size_in in PKT_QUEUE_IND_W.
REQ-006 SHALL have entry-output ports: out_valid out 1; out_ready in 1; out_seq out FLOW_SEQ_NUM_W; out_tx_id out TX_CNT_W; out_flow_id out FLOW_ID_W.
REQ-007 SHALL have writeback ports: wb_valid out 1; wb_flow_id out FLOW_ID_W; pkt_queue_head_out out PKT_QUEUE_IND_W; pkt_queue_size_out out PKT_QUEUE_IND_W; deq_done_cnt_out out PKT_QUEUE_IND_W.

Function
REQ-008 SHALL implement FSM states IDLE, POP and WB.
REQ-009 IDLE SHALL drive ctx_ready=1; on ctx_valid&&ctx_ready it SHALL latch all context inputs and set remaining=min(deq_cnt_in, pkt_queue_size_in).
REQ-010 On load, the FSM SHALL go to POP if remaining>0, else to WB.
REQ-011 POP SHALL present the slot at the head index of the latched queues on out_seq/out_tx_id, with out_valid registered and asserted from the cycle after load.
REQ-012 A handshake (out_valid&&out_ready) SHALL advance head by 1 modulo `MAX_PKT_QUEUE_SIZE (natural wrap 7->0), decrement size and remaining, and increment done count.
REQ-013 The FSM SHALL move POP->WB on the handshake that brings remaining to 0; at most one entry SHALL pop per cycle.
REQ-014 While out_valid=1 and out_ready=0, out_seq, out_tx_id and out_flow_id SHALL hold stable.
REQ-015 WB SHALL pulse wb_valid for exactly one cycle with the final head, size, done count and flow id, then return to IDLE.
REQ-016 ctx_ready SHALL be 0 in POP and WB, so ctx_valid is ignored while busy.
REQ-017 Size SHALL never underflow, because remaining is clamped to size at load.
REQ-018 Load-to-first-out_valid latency SHALL be 1 cycle; the minimum load-to-wb_valid time for N pops with out_ready held high SHALL be N+1 cycles.

Reset
REQ-019 rst SHALL force the FSM to IDLE and all outputs to 0 (ctx_ready becomes 1 after release).
REQ-020 rst asserted mid-operation SHALL discard the latched context, with no wb_valid pulse.

Configuration
REQ-021 With CR_DEQ_SKIP_NONE_EN defined, POP entries whose seq equals `FLOW_SEQ_NONE SHALL be consumed internally (head/size/remaining updated, one per cycle) without asserting out_valid, and SHALL not count in deq_done_cnt_out.
REQ-022 Without CR_DEQ_SKIP_NONE_EN, every entry, including `FLOW_SEQ_NONE entries, SHALL be emitted on the output handshake.

Structure
REQ-023 FSM state encoding and shared width localparams SHALL live in package cr_engine_pkg.
REQ-024 Slot selection (queue, index -> seq, tx_id) SHALL be the sub-module cr_queue_slot_mux.

Verification (MAX_PKT_QUEUE_SIZE=8)
REQ-025 Load head=2, size=3, cnt=2, out_ready=1: outputs slots 2,3 on consecutive cycles; wb head=4, size=1, done=2.
REQ-026 Load head=6, size=4, cnt=4: outputs slots 6,7,0,1; wb head=2, size=0.
REQ-027 Load size=0, cnt=3: no out_valid; wb_valid one cycle after load with inputs unchanged and done=0.
REQ-028 out_ready held low 5 cycles mid-drain: data stable and no head advance; drain resumes correctly after release.
REQ-029 rst asserted during POP, then new load: no stale wb_valid; the new flow processes normally.
REQ-030 With CR_DEQ_SKIP_NONE_EN, slot 3=`FLOW_SEQ_NONE, head=2, cnt=3: emits slots 2 and 4 only; wb head=5, done=2.

Source files
------------

// File: rtl/cr_engine_pkg.sv
// cr_engine_pkg: shared widths, FSM encoding and helpers for the dequeue engine.
// Width macros default here unless the build predefines them.
`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef FLOW_SEQ_NUM_W
`define FLOW_SEQ_NUM_W 16
`endif
`ifndef TX_CNT_W
`define TX_CNT_W 4
`endif
`ifndef MAX_PKT_QUEUE_SIZE
`define MAX_PKT_QUEUE_SIZE 8
`endif
`ifndef PKT_QUEUE_IND_W
`define PKT_QUEUE_IND_W 3
`endif
`ifndef MAX_QUEUE_BITS
`define MAX_QUEUE_BITS (`MAX_PKT_QUEUE_SIZE * `FLOW_SEQ_NUM_W)
`endif
`ifndef MAX_TX_ID_BITS
`define MAX_TX_ID_BITS (`MAX_PKT_QUEUE_SIZE * `TX_CNT_W)
`endif
`ifndef FLOW_SEQ_NONE
`define FLOW_SEQ_NONE {`FLOW_SEQ_NUM_W{1'b1}}
`endif

package cr_engine_pkg;

    localparam int SEQ_W      = `FLOW_SEQ_NUM_W;
    localparam int TX_W       = `TX_CNT_W;
    localparam int QUEUE_SIZE = `MAX_PKT_QUEUE_SIZE;
    localparam int IND_W      = `PKT_QUEUE_IND_W;
    localparam int QUEUE_BITS = `MAX_QUEUE_BITS;
    localparam int TX_ID_BITS = `MAX_TX_ID_BITS;

    localparam logic [SEQ_W-1:0] SEQ_NONE = `FLOW_SEQ_NONE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WB   = 2'd2
    } deq_state_e;

    function automatic logic [IND_W-1:0] ind_min(
        input logic [IND_W-1:0] a,
        input logic [IND_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    // Explicit wrap keeps the ring correct even if IND_W exceeds log2(QUEUE_SIZE).
    function automatic logic [IND_W-1:0] head_inc(input logic [IND_W-1:0] h);
        if (h >= IND_W'(QUEUE_SIZE - 1)) begin
            return '0;
        end
        return h + IND_W'(1);
    endfunction

endpackage

// File: rtl/cr_queue_slot_mux.sv
// cr_queue_slot_mux: selects one (seq, tx_id) slot from the packed
// flow queues by index.
module cr_queue_slot_mux
    import cr_engine_pkg::*;
(
    input  logic [QUEUE_BITS-1:0] queue,
    input  logic [TX_ID_BITS-1:0] tx_queue,
    input  logic [IND_W-1:0]      idx,
    output logic [SEQ_W-1:0]      seq,
    output logic [TX_W-1:0]       tx_id
);

    always_comb begin
        seq   = '0;
        tx_id = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (idx == IND_W'(i)) begin
                seq   = queue[i*SEQ_W +: SEQ_W];
                tx_id = tx_queue[i*TX_W +: TX_W];
            end
        end
    end

endmodule

// File: rtl/cr_dequeue.sv
// cr_dequeue: pops up to N entries from a flow's ring queue, then writes back
// head/size/done. Define CR_DEQ_SKIP_NONE_EN to drop empty slots internally.
module cr_dequeue
    import cr_engine_pkg::*;
#(
    parameter int FLOW_ID_W = `FLOW_ID_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctx_valid,
    output logic                 ctx_ready,
    input  logic [FLOW_ID_W-1:0] flow_id_in,
    input  logic [IND_W-1:0]     deq_cnt_in,
    input  logic [QUEUE_BITS-1:0] pkt_queue_in,
    input  logic [TX_ID_BITS-1:0] tx_id_queue_in,
    input  logic [IND_W-1:0]     pkt_queue_head_in,
    input  logic [IND_W-1:0]     pkt_queue_size_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEQ_W-1:0]     out_seq,
    output logic [TX_W-1:0]      out_tx_id,
    output logic [FLOW_ID_W-1:0] out_flow_id,
    output logic                 wb_valid,
    output logic [FLOW_ID_W-1:0] wb_flow_id,
    output logic [IND_W-1:0]     pkt_queue_head_out,
    output logic [IND_W-1:0]     pkt_queue_size_out,
    output logic [IND_W-1:0]     deq_done_cnt_out
);

    deq_state_e state, state_d;

    logic [FLOW_ID_W-1:0]  flow_q, flow_d;
    logic [QUEUE_BITS-1:0] queue_q, queue_d;
    logic [TX_ID_BITS-1:0] txq_q, txq_d;
    logic [IND_W-1:0]      head_q, head_d;
    logic [IND_W-1:0]      size_q, size_d;
    logic [IND_W-1:0]      rem_q, rem_d;
    logic [IND_W-1:0]      done_q, done_d;

    logic [SEQ_W-1:0] slot_seq;
    logic [TX_W-1:0]  slot_tx;
    logic             skip;
    logic             pop;
    logic             advance;
    logic             load;

    cr_queue_slot_mux u_slot_mux (
        .queue    (queue_q),
        .tx_queue (txq_q),
        .idx      (head_q),
        .seq      (slot_seq),
        .tx_id    (slot_tx)
    );

`ifdef CR_DEQ_SKIP_NONE_EN
    assign skip = (state == ST_POP) && (slot_seq == SEQ_NONE);
`else
    assign skip = 1'b0;
`endif

    // Valid decodes straight from flops, so it is glitch-free and stable on stall.
    assign out_valid = (state == ST_POP) && !skip;
    assign pop       = out_valid && out_ready;
    assign advance   = pop || skip;
    assign ctx_ready = (state == ST_IDLE) && !rst;
    assign load      = ctx_valid && ctx_ready;

    assign out_seq     = out_valid ? slot_seq : '0;
    assign out_tx_id   = out_valid ? slot_tx : '0;
    assign out_flow_id = flow_q;

    assign wb_valid           = (state == ST_WB);
    assign wb_flow_id         = flow_q;
    assign pkt_queue_head_out = head_q;
    assign pkt_queue_size_out = size_q;
    assign deq_done_cnt_out   = done_q;

    always_comb begin
        state_d = state;
        flow_d  = flow_q;
        queue_d = queue_q;
        txq_d   = txq_q;
        head_d  = head_q;
        size_d  = size_q;
        rem_d   = rem_q;
        done_d  = done_q;
        unique case (state)
            ST_IDLE: begin
                if (load) begin
                    flow_d  = flow_id_in;
                    queue_d = pkt_queue_in;
                    txq_d   = tx_id_queue_in;
                    head_d  = pkt_queue_head_in;
                    size_d  = pkt_queue_size_in;
                    rem_d   = ind_min(deq_cnt_in, pkt_queue_size_in);
                    done_d  = '0;
                    state_d = (rem_d != '0) ? ST_POP : ST_WB;
                end
            end
            ST_POP: begin
                if (advance) begin
                    head_d = head_inc(head_q);
                    size_d = size_q - IND_W'(1);
                    rem_d  = rem_q - IND_W'(1);
                    if (pop) begin
                        done_d = done_q + IND_W'(1);
                    end
                    if (rem_q == IND_W'(1)) begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            flow_q <= '0;
            queue_q <= '0;
            txq_q  <= '0;
            head_q <= '0;
            size_q <= '0;
            rem_q  <= '0;
            done_q <= '0;
        end else begin
            state  <= state_d;
            flow_q <= flow_d;
            queue_q <= queue_d;
            txq_q  <= txq_d;
            head_q <= head_d;
            size_q <= size_d;
            rem_q  <= rem_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_cr_dequeue.sv
// tb_cr_dequeue: directed vectors for cr_dequeue with hand-computed results.
// Slot i holds seq 16'hA000+i and tx_id i+3.
module tb_cr_dequeue;
    import cr_engine_pkg::*;

    logic clk = 0;
    logic rst = 1;
    logic ctx_valid = 0;
    logic ctx_ready;
    logic [7:0] flow_id_in = 0;
    logic [2:0] deq_cnt_in = 0;
    logic [127:0] pkt_queue_in = 0;
    logic [31:0] tx_id_queue_in = 0;
    logic [2:0] pkt_queue_head_in = 0;
    logic [2:0] pkt_queue_size_in = 0;
    logic out_valid;
    logic out_ready = 1;
    logic [15:0] out_seq;
    logic [3:0] out_tx_id;
    logic [7:0] out_flow_id;
    logic wb_valid;
    logic [7:0] wb_flow_id;
    logic [2:0] pkt_queue_head_out;
    logic [2:0] pkt_queue_size_out;
    logic [2:0] deq_done_cnt_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] got_seq [8];
    logic [3:0] got_tx [8];
    int n_out, wb_cyc, wb_seen;
    logic [7:0] wb_flow;
    logic [2:0] wb_head, wb_size, wb_done;

    always #5 clk = ~clk;

    cr_dequeue #(.FLOW_ID_W(8)) dut (
        .clk(clk), .rst(rst),
        .ctx_valid(ctx_valid), .ctx_ready(ctx_ready),
        .flow_id_in(flow_id_in), .deq_cnt_in(deq_cnt_in),
        .pkt_queue_in(pkt_queue_in), .tx_id_queue_in(tx_id_queue_in),
        .pkt_queue_head_in(pkt_queue_head_in),
        .pkt_queue_size_in(pkt_queue_size_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_seq(out_seq), .out_tx_id(out_tx_id),
        .out_flow_id(out_flow_id),
        .wb_valid(wb_valid), .wb_flow_id(wb_flow_id),
        .pkt_queue_head_out(pkt_queue_head_out),
        .pkt_queue_size_out(pkt_queue_size_out),
        .deq_done_cnt_out(deq_done_cnt_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sseq(input int i);
        return 16'hA000 + 16'(i % 8);
    endfunction

    function automatic logic [3:0] stx(input int i);
        return 4'((i % 8) + 3);
    endfunction

    task automatic fill_queue(input logic none_at_3);
        for (int i = 0; i < 8; i++) begin
            pkt_queue_in[i*16 +: 16] = sseq(i);
            tx_id_queue_in[i*4 +: 4] = stx(i);
        end
        if (none_at_3) pkt_queue_in[3*16 +: 16] = 16'hFFFF;
    endtask

    task automatic load(input logic [7:0] flow, input logic [2:0] cnt,
                        input logic [2:0] head, input logic [2:0] size);
        @(negedge clk);
        ctx_valid = 1;
        flow_id_in = flow;
        deq_cnt_in = cnt;
        pkt_queue_head_in = head;
        pkt_queue_size_in = size;
        @(posedge clk);
        #1 ctx_valid = 0;
        @(negedge clk);
    endtask

    task automatic collect(input int budget);
        n_out = 0;
        wb_seen = 0;
        wb_cyc = 0;
        for (int c = 1; c <= budget; c++) begin
            if (out_valid && out_ready && n_out < 8) begin
                got_seq[n_out] = out_seq;
                got_tx[n_out] = out_tx_id;
                n_out++;
            end
            if (wb_valid) begin
                wb_seen = 1;
                wb_cyc = c;
                wb_flow = wb_flow_id;
                wb_head = pkt_queue_head_out;
                wb_size = pkt_queue_size_out;
                wb_done = deq_done_cnt_out;
                @(negedge clk);
                check("wb_one_cycle", {31'b0, wb_valid}, 0);
                check("ready_after_wb", {31'b0, ctx_ready}, 1);
                return;
            end
            @(negedge clk);
        end
        check("wb_timeout", wb_seen, 1);
    endtask

    task automatic check_run(input string tag, input int first, input int n,
                             input int head, input int size, input int done,
                             input int flow);
        check({tag, "_count"}, n_out, n);
        for (int k = 0; k < n && k < n_out; k++) begin
            check({tag, "_seq"}, got_seq[k], sseq(first + k));
            check({tag, "_tx"}, got_tx[k], stx(first + k));
        end
        check({tag, "_wb_head"}, wb_head, head);
        check({tag, "_wb_size"}, wb_size, size);
        check({tag, "_wb_done"}, wb_done, done);
        check({tag, "_wb_flow"}, wb_flow, flow);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_queue(0);
        #12;
        check("rst_ctx_ready", {31'b0, ctx_ready}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_wb_valid", {31'b0, wb_valid}, 0);
        check("rst_head_out", pkt_queue_head_out, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("idle_ctx_ready", {31'b0, ctx_ready}, 1);

        // head=2 size=3 cnt=2: slots 2,3 back to back
        load(8'h11, 3'd2, 3'd2, 3'd3);
        check("t1_latency", {31'b0, out_valid}, 1);
        check("t1_busy", {31'b0, ctx_ready}, 0);
        check("t1_out_flow", out_flow_id, 8'h11);
        collect(20);
        check_run("t1", 2, 2, 4, 1, 2, 8'h11);
        check("t1_wb_time", wb_cyc, 3);

        // wrap 7->0
        load(8'h22, 3'd4, 3'd6, 3'd4);
        collect(20);
        check_run("t2", 6, 4, 2, 0, 4, 8'h22);
        check("t2_wb_time", wb_cyc, 5);

        // empty queue: straight to writeback
        load(8'h66, 3'd3, 3'd5, 3'd0);
        collect(20);
        check_run("t3", 5, 0, 5, 0, 0, 8'h66);
        check("t3_wb_time", wb_cyc, 1);

        // count clamped to size
        load(8'h77, 3'd5, 3'd3, 3'd2);
        collect(20);
        check_run("t4", 3, 2, 5, 0, 2, 8'h77);

        // stall mid-drain, plus a ctx_valid that must be ignored
        load(8'h88, 3'd4, 3'd0, 3'd5);
        check("t5_first", out_seq, sseq(0));
        @(negedge clk);
        out_ready = 0;
        ctx_valid = 1;
        flow_id_in = 8'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ctx_valid = 0;
            check("t5_stall_valid", {31'b0, out_valid}, 1);
            check("t5_stall_seq", out_seq, sseq(1));
            check("t5_stall_tx", out_tx_id, stx(1));
            check("t5_stall_flow", out_flow_id, 8'h88);
        end
        out_ready = 1;
        collect(20);
        check_run("t5", 1, 3, 4, 1, 4, 8'h88);

        // reset during POP discards context
        load(8'h44, 3'd4, 3'd0, 3'd4);
        @(negedge clk);
        rst = 1;
        #1;
        check("t6_rst_valid", {31'b0, out_valid}, 0);
        check("t6_rst_wb", {31'b0, wb_valid}, 0);
        check("t6_rst_ready", {31'b0, ctx_ready}, 0);
        check("t6_rst_head", pkt_queue_head_out, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_wb", {31'b0, wb_valid}, 0);
            check("t6_no_out", {31'b0, out_valid}, 0);
        end
        load(8'h33, 3'd2, 3'd5, 3'd2);
        collect(20);
        check_run("t6", 5, 2, 7, 0, 2, 8'h33);

        // empty slot 3 in the path
        fill_queue(1);
        load(8'h55, 3'd3, 3'd2, 3'd4);
        collect(20);
        check("t7_wb_head", wb_head, 5);
        check("t7_wb_size", wb_size, 1);
        check("t7_first", got_seq[0], sseq(2));
`ifdef CR_DEQ_SKIP_NONE_EN
        check("t7_count", n_out, 2);
        check("t7_second", got_seq[1], sseq(4));
        check("t7_wb_done", wb_done, 2);
`else
        check("t7_count", n_out, 3);
        check("t7_none", got_seq[1], 16'hFFFF);
        check("t7_third", got_seq[2], sseq(4));
        check("t7_wb_done", wb_done, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
